// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Per-GPR in-flight write tracker between decode and register read.
//            Stalls decode while a needed source has outstanding producers,
//            counts dispatched writes up and completed writebacks down, and
//            flags writebacks to registers with nothing pending.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid,
  input  logic       pipe_stall,
  input  logic       flush,
  input  logic       in1_needed,
  input  logic       in2_needed,
  input  logic       in3_needed,
  input  logic       in4_needed,
  input  logic [2:0] in1,
  input  logic [2:0] in2,
  input  logic [2:0] in3,
  input  logic [2:0] in4,
  input  logic       eax_needed,
  input  logic       esp_needed,
  input  logic       ld_reg1,
  input  logic       ld_reg2,
  input  logic       ld_reg3,
  input  logic [2:0] dreg1,
  input  logic [2:0] dreg2,
  input  logic [2:0] dreg3,
  input  logic       wb_ld1,
  input  logic       wb_ld2,
  input  logic       wb_ld3,
  input  logic [2:0] wb_dreg1,
  input  logic [2:0] wb_dreg2,
  input  logic [2:0] wb_dreg3,
  output logic       dep_stall,
  output logic       dispatch,
  output logic [7:0] busy_vec,
  output logic       sb_err
);

  // Sums carry two extra bits so cnt + alloc (alloc <= 3) never wraps.
  localparam int               SUM_W     = CNT_W + 2;
  localparam logic [SUM_W-1:0] C_CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_cnt [8];
  logic [7:0]       r_busy;
  logic             r_sb_err;

  logic [1:0]       w_alloc   [8];
  logic [1:0]       w_rel     [8];
  logic [CNT_W-1:0] w_rel_eff [8];
  logic [SUM_W-1:0] w_net     [8];
  logic [CNT_W-1:0] w_cnt_nxt [8];
  logic [7:0]       w_nz;
  logic [7:0]       w_ovf_vec;
  logic [7:0]       w_uflow_vec;
  logic             w_src_busy;
  logic             w_ovf;
  logic             w_dispatch;

  // Per-register alloc/release tallies with clamped release, overflow and underflow
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      w_alloc[r]     = 2'(ld_reg1 && (dreg1 == 3'(r)))
                     + 2'(ld_reg2 && (dreg2 == 3'(r)))
                     + 2'(ld_reg3 && (dreg3 == 3'(r)));
      w_rel[r]       = 2'(wb_ld1 && (wb_dreg1 == 3'(r)))
                     + 2'(wb_ld2 && (wb_dreg2 == 3'(r)))
                     + 2'(wb_ld3 && (wb_dreg3 == 3'(r)));
      w_uflow_vec[r] = SUM_W'(w_rel[r]) > SUM_W'(r_cnt[r]);
      w_rel_eff[r]   = w_uflow_vec[r] ? r_cnt[r] : CNT_W'(w_rel[r]);
      w_net[r]       = SUM_W'(r_cnt[r]) - SUM_W'(w_rel_eff[r]) + SUM_W'(w_alloc[r]);
      w_ovf_vec[r]   = (w_alloc[r] != 2'd0) && (w_net[r] > C_CNT_MAX);
      w_nz[r]        = (r_cnt[r] != '0);
    end
  end

  // Source test looks only at registered counts: a same-cycle writeback does not bypass
  assign w_src_busy = (in1_needed && w_nz[in1]) | (in2_needed && w_nz[in2])
                    | (in3_needed && w_nz[in3]) | (in4_needed && w_nz[in4])
                    | (eax_needed && w_nz[0])   | (esp_needed && w_nz[4]);
  assign w_ovf      = |w_ovf_vec;
  assign dep_stall  = dec_valid & (w_src_busy | w_ovf);
  assign w_dispatch = dec_valid & ~dep_stall & ~pipe_stall;
  assign dispatch   = w_dispatch;

  // Next counter value: clamped release, plus allocation only when dispatching
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      w_cnt_nxt[r] = CNT_W'(SUM_W'(r_cnt[r]) - SUM_W'(w_rel_eff[r])
                   + (w_dispatch ? SUM_W'(w_alloc[r]) : '0));
    end
  end

  // Pending counters and busy mirror; flush clears everything and suppresses allocation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) r_cnt[r] <= '0;
      r_busy <= 8'h00;
    end else if (flush) begin
      for (int r = 0; r < 8; r++) r_cnt[r] <= '0;
      r_busy <= 8'h00;
    end else begin
      for (int r = 0; r < 8; r++) begin
        r_cnt[r]  <= w_cnt_nxt[r];
        r_busy[r] <= (w_cnt_nxt[r] != '0);
      end
    end
  end

  // Sticky underflow flag: only reset clears it, flush leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else if (!flush && (|w_uflow_vec)) begin
      r_sb_err <= 1'b1;
    end
  end

  assign busy_vec = r_busy;
  assign sb_err   = r_sb_err;

endmodule
`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Per-GPR in-flight write tracker sitting between decode and the register-read stage.
- Consumes decoded source addresses in1..in4 and implicit EAX/ESP needs, plus destination addresses dreg1..dreg3 with load enables, as produced by decode's register-address/dependency logic.
- Raises a dependency stall until all producers of a needed source have written back.
- Allocates pending-write counts on dispatch and releases them on writeback; cleared by flush.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter; maximum count is 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode stage holds a valid instruction
- pipe_stall  in  1  downstream stall; blocks dispatch
- flush  in  1  synchronous clear of all pending state (branch/exception)
- in1_needed, in2_needed, in3_needed, in4_needed  in  1 each  source-use flags
- in1, in2, in3, in4  in  3 each  source GPR addresses
- eax_needed, esp_needed  in  1 each  implicit EAX(0) / ESP(4) reads
- ld_reg1, ld_reg2, ld_reg3  in  1 each  destination write enables
- dreg1, dreg2, dreg3  in  3 each  destination GPR addresses
- wb_ld1, wb_ld2, wb_ld3  in  1 each  writeback-complete enables
- wb_dreg1, wb_dreg2, wb_dreg3  in  3 each  writeback GPR addresses
- dep_stall  out  1  combinational; hold decode
- dispatch  out  1  combinational; dec_valid & ~dep_stall & ~pipe_stall
- busy_vec  out  8  registered; bit r = (cnt[r] != 0)
- sb_err  out  1  sticky underflow error flag

Behaviour:
- State: cnt[0..7], each CNT_W bits, plus sb_err.
- Reset (rst_n low, asynchronous): all cnt = 0, busy_vec = 0, sb_err = 0.
- Release count: rel[r] = number of wb_ldk with wb_dregk == r (0..3).
- Allocation count: alloc[r] = number of ld_regk with dregk == r (0..3).
  - Duplicates within one instruction count individually; e.g. cxchg with dreg1 == dreg2 gives alloc 2.
- Source-busy test uses registered cnt only. Same-cycle writeback does not bypass the stall; the stall clears one cycle after the release.
- src_busy is the OR of:
  - inK_needed & cnt[inK] != 0, for K = 1..4
  - eax_needed & cnt[0] != 0
  - esp_needed & cnt[4] != 0
- ovf: for any r with alloc[r] != 0, cnt[r] - min(rel[r], cnt[r]) + alloc[r] > 2^CNT_W-1.
- dep_stall = dec_valid & (src_busy | ovf). It is 0 when dec_valid = 0.
- Next-state per register, all in one cycle:
  - cnt_next = cnt - rel_eff + (dispatch ? alloc : 0), where rel_eff = min(rel, cnt).
  - Simultaneous alloc and release on the same register nets out.
  - Example: cnt = 1, one release, one alloc → cnt stays 1.
- Underflow: rel[r] > cnt[r] clamps cnt at 0 and sets sb_err.
  - sb_err stays set until reset. Flush does not clear it.
- Flush has priority over dispatch and writeback: all cnt = 0 on the next edge, and no allocation occurs that cycle.
  - dispatch may still read 1 combinationally; the front end must ignore it under flush.
- Instruction with no ld_regk asserted: dispatches without allocating; only sources are checked.
- Self-dependency (source and destination are the same register, free): no stall, allocation occurs.
- busy_vec updates on the same edge as cnt.
- rst_n asserted mid-operation drops all pending state immediately, regardless of clk.

Test Plan:
- Reset then idle: rst_n low mid-cycle → busy_vec = 8'h00, dep_stall = 0, sb_err = 0 immediately.
- RAW stall:
  - Dispatch with ld_reg1 = 1, dreg1 = 3 → busy_vec = 8'h08.
  - Next instruction with in3_needed = 1, in3 = 3 → dep_stall = 1.
  - wb_ld1 = 1, wb_dreg1 = 3 at edge N → dep_stall = 0 at cycle N+1, busy_vec = 0.
- Implicit ESP:
  - push allocates dreg2 = 4; a following instruction with esp_needed = 1 stalls.
  - A following instruction with in1 = 4 but in1_needed = 0 does not stall.
- Saturation (CNT_W = 2):
  - Three dispatches to dreg1 = 0 → cnt[0] = 3.
  - Fourth alloc to reg 0 → dep_stall = 1 via ovf.
  - Same cycle with wb_ld1 to reg 0 → dispatch = 1, cnt[0] stays 3.
- Triple writeback plus dispatch:
  - cnt[1] = 2, cnt[2] = 1; wb to 1, 1, 2 while dispatching ld_reg1 to 2 → cnt[1] = 0, cnt[2] = 1.
- Flush and underflow:
  - flush with cnt[5] = 2 and a dispatch pending → all cnt = 0, busy_vec = 0.
  - Then wb_ld1 to reg 5 → sb_err = 1, and it remains 1 after a further flush.
